// File: rtl/instr_fetch_decode_pkg.sv
// Shared types for the instruction fetch/decode block: FSM states,
// instruction field layout and the halt opcode.
package instr_fetch_decode_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned REG_W   = 1;
  localparam int unsigned IMM_W   = 9;

  localparam logic [OPC_W-1:0] OP_HLT = 6'b000000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  // Instruction word layout, MSB first: opcode [15:10], reg_sel [9], imm [8:0]
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] reg_sel;
    logic [IMM_W-1:0] imm;
  } instr_t;

endpackage

// File: rtl/instr_fetch_decode_pc_reg.sv
// Program counter: synchronous reset, redirect load, and increment that
// wraps modulo 2^ADDR_W.
module pc_reg #(
  parameter int unsigned         ADDR_W   = 10,
  parameter logic [ADDR_W-1:0]   PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= PC_RESET;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Single-issue instruction fetch and field decode: requests a word at the PC,
// holds it in IR and presents the raw fields until the consumer accepts.
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_valid,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [OPC_W-1:0]   opcode,
  output logic               reg_sel,
  output logic [IMM_W-1:0]   imm,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted
);

  state_t              state, state_nxt;
  instr_t              ir;
  logic                ir_load;
  logic                pc_load;
  logic                pc_inc;
  logic [ADDR_W-1:0]   pc_q;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .PC_RESET (PC_RESET)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (pc_load),
    .inc    (pc_inc),
    .target (br_target),
    .pc     (pc_q)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and register-update strobes
  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (mem_valid) begin
          ir_load   = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (dec_ready) begin
          if (ir.opcode == OP_HLT) begin
            state_nxt = ST_HALT;
          end else begin
            pc_load   = br_taken;
            pc_inc    = ~br_taken;
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Instruction register and status flags, registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      ir        <= '0;
      mem_req   <= 1'b0;
      dec_valid <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      if (ir_load) ir <= instr_t'(mem_rdata);
      mem_req   <= (state_nxt == ST_FETCH) || (state_nxt == ST_WAIT);
      dec_valid <= (state_nxt == ST_ISSUE);
      busy      <= (state_nxt == ST_FETCH) || (state_nxt == ST_WAIT) ||
                   (state_nxt == ST_ISSUE);
      halted    <= (state_nxt == ST_HALT);
    end
  end

  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign opcode   = ir.opcode;
  assign reg_sel  = ir.reg_sel;
  assign imm      = ir.imm;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: a cycle table of inputs and expected
// outputs, plus hand sequences for long WAIT and reset during WAIT.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst, start, mem_valid, dec_ready, br_taken;
  logic [15:0] mem_rdata;
  logic [9:0]  br_target;

  logic        mem_req, dec_valid, reg_sel, busy, halted;
  logic [9:0]  mem_addr, pc;
  logic [5:0]  opcode;
  logic [8:0]  imm;

  logic        mem_req2, dec_valid2, reg_sel2, busy2, halted2;
  logic [9:0]  mem_addr2, pc2;
  logic [5:0]  opcode2;
  logic [8:0]  imm2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_decode dut (
    .clk(clk), .rst(rst), .start(start), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .opcode(opcode), .reg_sel(reg_sel), .imm(imm),
    .br_taken(br_taken), .br_target(br_target), .pc(pc), .busy(busy),
    .halted(halted)
  );

  // Same stimulus, PC reset at the top of the address space
  instr_fetch_decode #(.ADDR_W(10), .PC_RESET(10'h3FF)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .dec_valid(dec_valid2),
    .dec_ready(dec_ready), .opcode(opcode2), .reg_sel(reg_sel2), .imm(imm2),
    .br_taken(br_taken), .br_target(br_target), .pc(pc2), .busy(busy2),
    .halted(halted2)
  );

  typedef struct {
    logic        rst, start, mv;
    logic [15:0] rdata;
    logic        rdy, br;
    logic [9:0]  tgt;
    logic        req;
    logic [9:0]  addr, addr2;
    logic        dv;
    logic [5:0]  opc;
    logic        rs;
    logic [8:0]  imm;
    logic [9:0]  pc;
    logic        busy, halted;
  } vec_t;

  task automatic chk(input string name, input int row, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic mv,
                       input logic [15:0] rd, input logic rdy, input logic br,
                       input logic [9:0] tgt);
    @(negedge clk);
    rst = r; start = s; mem_valid = mv; mem_rdata = rd;
    dec_ready = rdy; br_taken = br; br_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input int row, input vec_t v);
    chk("mem_req",   row, 16'(mem_req),   16'(v.req));
    chk("mem_addr",  row, 16'(mem_addr),  16'(v.addr));
    chk("wrap_addr", row, 16'(mem_addr2), 16'(v.addr2));
    chk("dec_valid", row, 16'(dec_valid), 16'(v.dv));
    chk("opcode",    row, 16'(opcode),    16'(v.opc));
    chk("reg_sel",   row, 16'(reg_sel),   16'(v.rs));
    chk("imm",       row, 16'(imm),       16'(v.imm));
    chk("pc",        row, 16'(pc),        16'(v.pc));
    chk("busy",      row, 16'(busy),      16'(v.busy));
    chk("halted",    row, 16'(halted),    16'(v.halted));
  endtask

  vec_t vec [18];
  vec_t hv;

  initial begin
    rst = 1'b0; start = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
    dec_ready = 1'b0; br_taken = 1'b0; br_target = '0;

    //          rst st mv rdata     rdy br tgt      req addr    addr2   dv opc   rs imm     pc      bsy hlt
    vec[0]  = '{1, 0, 0, 16'h0000, 0, 0, 10'h000, 0, 10'h000, 10'h3FF, 0, 6'h00, 0, 9'h000, 10'h000, 0, 0};
    vec[1]  = '{0, 0, 1, 16'hFFFF, 1, 1, 10'h123, 0, 10'h000, 10'h3FF, 0, 6'h00, 0, 9'h000, 10'h000, 0, 0};
    vec[2]  = '{0, 1, 0, 16'h0000, 0, 0, 10'h000, 1, 10'h000, 10'h3FF, 0, 6'h00, 0, 9'h000, 10'h000, 1, 0};
    vec[3]  = '{0, 0, 0, 16'h0000, 0, 0, 10'h000, 1, 10'h000, 10'h3FF, 0, 6'h00, 0, 9'h000, 10'h000, 1, 0};
    vec[4]  = '{0, 1, 0, 16'h0000, 1, 0, 10'h000, 1, 10'h000, 10'h3FF, 0, 6'h00, 0, 9'h000, 10'h000, 1, 0};
    vec[5]  = '{0, 0, 1, 16'hFD66, 0, 0, 10'h000, 0, 10'h000, 10'h3FF, 1, 6'h3F, 0, 9'h166, 10'h000, 1, 0};
    vec[6]  = '{0, 0, 1, 16'hFFFF, 0, 1, 10'h200, 0, 10'h000, 10'h3FF, 1, 6'h3F, 0, 9'h166, 10'h000, 1, 0};
    vec[7]  = '{0, 1, 0, 16'h0000, 0, 1, 10'h200, 0, 10'h000, 10'h3FF, 1, 6'h3F, 0, 9'h166, 10'h000, 1, 0};
    vec[8]  = '{0, 0, 0, 16'h0000, 0, 0, 10'h000, 0, 10'h000, 10'h3FF, 1, 6'h3F, 0, 9'h166, 10'h000, 1, 0};
    vec[9]  = '{0, 0, 0, 16'h0000, 1, 0, 10'h000, 1, 10'h001, 10'h000, 0, 6'h3F, 0, 9'h166, 10'h001, 1, 0};
    vec[10] = '{0, 0, 0, 16'h0000, 0, 0, 10'h000, 1, 10'h001, 10'h000, 0, 6'h3F, 0, 9'h166, 10'h001, 1, 0};
    vec[11] = '{0, 0, 1, 16'h0BFF, 0, 0, 10'h000, 0, 10'h001, 10'h000, 1, 6'h02, 1, 9'h1FF, 10'h001, 1, 0};
    vec[12] = '{0, 0, 0, 16'h0000, 1, 1, 10'h200, 1, 10'h200, 10'h200, 0, 6'h02, 1, 9'h1FF, 10'h200, 1, 0};
    vec[13] = '{0, 0, 0, 16'h0000, 1, 1, 10'h055, 1, 10'h200, 10'h200, 0, 6'h02, 1, 9'h1FF, 10'h200, 1, 0};
    vec[14] = '{0, 0, 1, 16'h005E, 0, 0, 10'h000, 0, 10'h200, 10'h200, 1, 6'h00, 0, 9'h05E, 10'h200, 1, 0};
    vec[15] = '{0, 0, 0, 16'h0000, 1, 1, 10'h055, 0, 10'h200, 10'h200, 0, 6'h00, 0, 9'h05E, 10'h200, 0, 1};
    vec[16] = '{0, 1, 1, 16'hFFFF, 1, 0, 10'h000, 0, 10'h200, 10'h200, 0, 6'h00, 0, 9'h05E, 10'h200, 0, 1};
    vec[17] = '{1, 1, 0, 16'h0000, 0, 0, 10'h000, 0, 10'h000, 10'h3FF, 0, 6'h00, 0, 9'h000, 10'h000, 0, 0};

    for (int i = 0; i < 18; i++) begin
      drive(vec[i].rst, vec[i].start, vec[i].mv, vec[i].rdata,
            vec[i].rdy, vec[i].br, vec[i].tgt);
      chk_all(i, vec[i]);
    end

    // Long WAIT without a memory response: request stays up, no timeout
    hv = '{0, 0, 0, 16'h0000, 0, 0, 10'h000, 1, 10'h000, 10'h3FF, 0, 6'h00, 0, 9'h000, 10'h000, 1, 0};
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 10'h000);
    chk_all(100, hv);
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 10'h2AA);
      chk("wait_req", 101 + c, 16'(mem_req), 16'h0001);
      chk("wait_dv",  101 + c, 16'(dec_valid), 16'h0000);
    end

    // Reset in WAIT, then a late response must not load IR
    hv = '{0, 0, 0, 16'h0000, 0, 0, 10'h000, 0, 10'h000, 10'h3FF, 0, 6'h00, 0, 9'h000, 10'h000, 0, 0};
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 10'h000);
    chk_all(200, hv);
    drive(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 10'h000);
    chk_all(201, hv);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 10'h000);
    chk_all(202, hv);

    // Fresh fetch after reset starts again from PC_RESET
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 10'h000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 10'h000);
    drive(1'b0, 1'b0, 1'b1, 16'h7C01, 1'b0, 1'b0, 10'h000);
    hv = '{0, 0, 0, 16'h0000, 0, 0, 10'h000, 0, 10'h000, 10'h3FF, 1, 6'h1F, 0, 9'h001, 10'h000, 1, 0};
    chk_all(300, hv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
